// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- receive side of the board UART link.
//
// Deserialises an asynchronous serial line into DATA_BIT-wide words. Frame:
// 1 start bit (low), DATA_BIT data bits LSB first, an optional even-parity bit,
// and STOP_BIT stop bits (high). Good words go to a one-entry holding register
// with a valid/ready interface. Errors are reported as single-cycle pulses.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   When defined, each sample point takes the 2-of-3 majority of the
//   synchronised line around the nominal sample count. This needs
//   CLOCK_PER_BIT >= 8. When undefined, a single sample is taken and the vote
//   logic is absent.
//
// Ports:
//   clk             in   system clock
//   a_reset_n       in   asynchronous reset, active low
//   uart_in         in   serial line, asynchronous to clk, idles high
//   valid_out       out  data_out holds an unconsumed word
//   ready_in        in   consumer accepts the word when valid_out && ready_in
//   data_out        out  received word, stable while valid_out is high
//   busy_out        out  receiver FSM is not idle
//   parity_err_out  out  pulse: parity mismatch, word discarded
//   frame_err_out   out  pulse: a stop bit sampled low, word discarded
//   overrun_err_out out  pulse: good word arrived while the holding register
//                        was full; the new word is discarded
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_BIT      = 8,
   parameter int PARITY_BIT    = 1,
   parameter int STOP_BIT      = 1,
   parameter int CLOCK_PER_BIT = 1000
) (
   input  logic                clk,
   input  logic                a_reset_n,
   input  logic                uart_in,
   output logic                valid_out,
   input  logic                ready_in,
   output logic [DATA_BIT-1:0] data_out,
   output logic                busy_out,
   output logic                parity_err_out,
   output logic                frame_err_out,
   output logic                overrun_err_out
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLOCK_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'((CLOCK_PER_BIT / 2) - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BIT - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BIT - 1);

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;

   // Synchroniser resets to the idle (high) line level so reset release never
   // looks like a start edge.
   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make both flops capture the values
         // from before the edge, giving a real two-stage chain; blocking
         // assignments here would collapse it into a single flop.
         rx_meta <= uart_in;
         rx_s    <= rx_meta;
      end
   end

   // edge_in drives start/break detection; sample is the value taken at a
   // sample point.
   logic edge_in;
   logic sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic rx_d1;
   logic rx_d2;

   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         rx_d1 <= 1'b1;
         rx_d2 <= 1'b1;
      end else begin
         rx_d1 <= rx_s;
         rx_d2 <= rx_d1;
      end
   end

   // The whole timebase runs one cycle late, so rx_d1 sits at the nominal
   // sample point. rx_d2 and rx_s are its neighbours at c-1 and c+1, and the
   // decision lands at c+1 in line time.
   assign edge_in = rx_d1;
   assign sample  = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
   assign edge_in = rx_s;
   assign sample  = rx_s;
`endif

   // ---------------------------------------------------------------------------
   // Receiver FSM, bit timer and holding register
   // ---------------------------------------------------------------------------
   state_t              state;
   logic [15:0]         count;
   logic [3:0]          bit_cnt;
   logic [DATA_BIT-1:0] shift_reg;
   logic [DATA_BIT-1:0] shift_next;
   logic                parity_bad;
   logic                frame_bad;
   logic                done;

   logic tick;
   logic half;

   assign tick     = (count == BIT_LAST);
   assign half     = (count == HALF_LAST);
   assign busy_out = (state != ST_IDLE);

   // New bits enter at the MSB and shift right, so the first bit received ends
   // up in bit 0. Written as a shift followed by an MSB overwrite, this also
   // works when DATA_BIT is 1.
   always_comb begin
      // NOTE: shift_next gets a full default before it is modified; any path
      // through a combinational block that leaves a variable unassigned
      // infers a latch.
      shift_next             = shift_reg >> 1;
      shift_next[DATA_BIT-1] = sample;
   end

   always_ff @(posedge clk or negedge a_reset_n) begin
      if (!a_reset_n) begin
         // NOTE: the holding register and shift register reset too. A
         // mid-frame reset must leave no stale word behind, and this is a
         // single register rather than a RAM array, so the reset costs
         // nothing.
         state           <= ST_IDLE;
         count           <= '0;
         bit_cnt         <= '0;
         shift_reg       <= '0;
         parity_bad      <= 1'b0;
         frame_bad       <= 1'b0;
         done            <= 1'b0;
         valid_out       <= 1'b0;
         data_out        <= '0;
         parity_err_out  <= 1'b0;
         frame_err_out   <= 1'b0;
         overrun_err_out <= 1'b0;
      end else begin
         parity_err_out  <= 1'b0;
         frame_err_out   <= 1'b0;
         overrun_err_out <= 1'b0;
         done            <= 1'b0;

         // Consume. A load further down overrides this in the same cycle.
         if (valid_out && ready_in) begin
            valid_out <= 1'b0;
         end

         // Frame completion, one cycle after the last stop sample.
         if (done) begin
            if (frame_bad) begin
               frame_err_out <= 1'b1;
            end else if (parity_bad) begin
               parity_err_out <= 1'b1;
            end else if (!valid_out || ready_in) begin
               data_out  <= shift_reg;
               valid_out <= 1'b1;
            end else begin
               overrun_err_out <= 1'b1;
            end
         end

         // Bit timer. The state cases below clear it on every transition.
         if (state == ST_IDLE || tick) begin
            count <= '0;
         end else begin
            count <= count + 16'd1;
         end

         case (state)
            ST_IDLE: begin
               if (!edge_in) begin
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (half) begin
                  count <= '0;
                  if (!sample) begin
                     state      <= ST_DATA;
                     bit_cnt    <= '0;
                     shift_reg  <= '0;
                     parity_bad <= 1'b0;
                     frame_bad  <= 1'b0;
                  end else begin
                     // The line went back high: treat it as a glitch and
                     // raise no error.
                     state <= ST_IDLE;
                  end
               end
            end

            ST_DATA: begin
               if (tick) begin
                  shift_reg <= shift_next;
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_BIT > 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end

            ST_PARITY: begin
               if (tick) begin
                  parity_bad <= sample ^ (^shift_reg);
                  state      <= ST_STOP;
               end
            end

            ST_STOP: begin
               if (tick) begin
                  if (!sample) begin
                     frame_bad <= 1'b1;
                  end
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     done    <= 1'b1;
                     // A low final stop bit means a break or a stuck line.
                     // Wait for the line to go high again before looking for
                     // another start.
                     state <= sample ? ST_IDLE : ST_BREAK;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end

            ST_BREAK: begin
               if (edge_in) begin
                  state <= ST_IDLE;
                  count <= '0;
               end
            end

            default: begin
               state <= ST_IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Configuration: 8 data bits, even parity, 1 stop bit, 16 clocks per bit.
// Each stimulus task pushes the response it expects into a scoreboard queue.
// A monitor process running on the falling edge pops an entry and compares it
// every time the DUT pulses an error or completes a valid/ready handshake.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int DATA_BIT      = 8;
   localparam int PARITY_BIT    = 1;
   localparam int STOP_BIT      = 1;
   localparam int CLOCK_PER_BIT = 16;

   logic                clk;
   logic                a_reset_n;
   logic                uart_in;
   logic                valid_out;
   logic                ready_in;
   logic [DATA_BIT-1:0] data_out;
   logic                busy_out;
   logic                parity_err_out;
   logic                frame_err_out;
   logic                overrun_err_out;

   uart_rx #(
      .DATA_BIT      (DATA_BIT),
      .PARITY_BIT    (PARITY_BIT),
      .STOP_BIT      (STOP_BIT),
      .CLOCK_PER_BIT (CLOCK_PER_BIT)
   ) dut (
      .clk             (clk),
      .a_reset_n       (a_reset_n),
      .uart_in         (uart_in),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .data_out        (data_out),
      .busy_out        (busy_out),
      .parity_err_out  (parity_err_out),
      .frame_err_out   (frame_err_out),
      .overrun_err_out (overrun_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {EV_NONE, EV_DATA, EV_PAR, EV_FRM, EV_OVR} ev_kind_e;

   typedef struct {
      ev_kind_e   kind;
      logic [7:0] data;
   } ev_t;

   ev_t sb[$];
   int  n_pass  = 0;
   int  n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input ev_kind_e kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic take_event(input ev_kind_e kind, input logic [7:0] data);
      ev_t e;
      if (sb.size() == 0) begin
         check("unexpected_event", 32'(kind), 32'(EV_NONE));
      end else begin
         e = sb.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (e.kind == EV_DATA && kind == EV_DATA) begin
            check("event_data", 32'(data), 32'(e.data));
         end
      end
   endtask

   // Monitor: every error pulse and every accepted word must match the next
   // scoreboard entry. A pulse held high for two cycles or a word consumed
   // twice pops an extra entry and is caught.
   always @(negedge clk) begin
      if (a_reset_n) begin
         if (frame_err_out)          take_event(EV_FRM, 8'h00);
         if (parity_err_out)         take_event(EV_PAR, 8'h00);
         if (overrun_err_out)        take_event(EV_OVR, 8'h00);
         if (valid_out && ready_in)  take_event(EV_DATA, data_out);
      end
   end

   // ---------------------------------------------------------------------------
   // Line driver. One cycle of line time is the value driven just after a
   // rising edge. Bit centre is cycle CLOCK_PER_BIT/2 within the bit.
   // ---------------------------------------------------------------------------
   task automatic send_bit(input logic v, input bit glitch);
      for (int j = 0; j < CLOCK_PER_BIT; j++) begin
         @(posedge clk);
         #1;
         uart_in = (glitch && j == CLOCK_PER_BIT / 2) ? ~v : v;
      end
   endtask

   // Sends a frame and leaves the line at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input bit flip_par,
                             input bit stop_low, input bit glitch);
      logic par;
      par = (^d) ^ flip_par;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < DATA_BIT; i++) send_bit(d[i], glitch);
      send_bit(par, glitch);
      send_bit(~stop_low, 1'b0);
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      uart_in = 1'b1;
      repeat (n - 1) @(posedge clk);
      #1;
   endtask

   // Reference model: the expected outcome of a frame, given the holding
   // register is free.
   function automatic ev_kind_e model(input bit flip_par, input bit stop_low);
      if (stop_low)      return EV_FRM;
      else if (flip_par) return EV_PAR;
      else               return EV_DATA;
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0] d;
      int         mode;
      bit         fp;
      bit         sl;
      int         guard;

      uart_in   = 1'b1;
      ready_in  = 1'b1;
      a_reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",   32'(valid_out),       32'h0);
      check("rst_data",    32'(data_out),        32'h0);
      check("rst_busy",    32'(busy_out),        32'h0);
      check("rst_par_err", 32'(parity_err_out),  32'h0);
      check("rst_frm_err", 32'(frame_err_out),   32'h0);
      check("rst_ovr_err", 32'(overrun_err_out), 32'h0);
      a_reset_n = 1'b1;
      idle(2 * CLOCK_PER_BIT);

      // Good frame 0xA5
      expect_ev(EV_DATA, 8'hA5);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      idle(2 * CLOCK_PER_BIT);

      // Parity forced wrong on 0x3C
      expect_ev(EV_PAR, 8'h00);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      idle(2 * CLOCK_PER_BIT);

      // Break: 0x55 with a low stop bit, then the line held low for 40 bits
      expect_ev(EV_FRM, 8'h00);
      send_frame(8'h55, 1'b0, 1'b1, 1'b0);
      repeat (10 * CLOCK_PER_BIT) @(posedge clk);
      #1;
      check("break_busy_early", 32'(busy_out), 32'h1);
      repeat (29 * CLOCK_PER_BIT) @(posedge clk);
      #1;
      check("break_busy_late", 32'(busy_out), 32'h1);
      idle(3 * CLOCK_PER_BIT);
      check("break_released", 32'(busy_out), 32'h0);

      // Short low glitch on an idle line: false start with no outputs
      for (int j = 0; j < 5; j++) begin
         @(posedge clk);
         #1;
         uart_in = 1'b0;
      end
      @(posedge clk);
      #1;
      uart_in = 1'b1;
      check("glitch_busy_start", 32'(busy_out), 32'h1);
      repeat (2 * CLOCK_PER_BIT) @(posedge clk);
      #1;
      check("glitch_busy_end", 32'(busy_out), 32'h0);

      // Overrun: hold 0x11, then 0x22 arrives while the register is full
      ready_in = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      idle(2 * CLOCK_PER_BIT);
      check("hold_valid", 32'(valid_out), 32'h1);
      expect_ev(EV_OVR, 8'h00);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      idle(2 * CLOCK_PER_BIT);
      check("ovr_data_kept", 32'(data_out), 32'h11);
      check("ovr_valid_kept", 32'(valid_out), 32'h1);
      expect_ev(EV_DATA, 8'h11);
      ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ovr_valid_drop", 32'(valid_out), 32'h0);

      // A 1-clk inverted glitch at each data and parity bit centre
`ifdef UART_RX_MAJORITY_VOTE_EN
      expect_ev(EV_DATA, 8'hF0);
`else
      expect_ev(EV_PAR, 8'h00);
`endif
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
      idle(2 * CLOCK_PER_BIT);

      // Randomised frames against the reference model
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         mode = $urandom_range(0, 7);
         fp   = (mode == 0);
         sl   = (mode == 1);
         expect_ev(model(fp, sl), d);
         send_frame(d, fp, sl, 1'b0);
         idle($urandom_range(4, 40));
      end
      idle(2 * CLOCK_PER_BIT);

      // Reset in the middle of a frame loses the word silently
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      a_reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy_out), 32'h0);
      check("midrst_valid", 32'(valid_out), 32'h0);
      uart_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      a_reset_n = 1'b1;
      idle(4 * CLOCK_PER_BIT);
      check("midrst_idle", 32'(busy_out), 32'h0);

      // All expected events must have been seen, within a bounded wait
      guard = 0;
      while (sb.size() != 0 && guard < 20 * CLOCK_PER_BIT) begin
         @(posedge clk);
         guard++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
